key_extractor: RTL and testbench
================================

Name: key_extractor

Overview:
- Parses received Ethernet frames on the db_clk domain and produces one 96-bit flow key plus a 4-bit flag per qualifying IPv4 TCP/UDP frame.
- Sits directly upstream of db_top and drives its in_key/in_flag/in_valid interface.
- Input is the 64-bit receive stream from the Ethernet path; there is no backpressure in either direction.

Parameters:
- DATA_WIDTH, 64, stream data width in bits; only 64 is supported.
- KEY_SIZE, 96, key width: {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0]}.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  input  1  db_clk; all logic is synchronous to it.
- rst  input  1  synchronous, active-high reset.
- s_tdata  input  64  frame data; byte n of the beat is at [8n+7:8n]; network byte order within fields.
- s_tvalid  input  1  beat valid.
- s_tlast  input  1  last beat of the frame.
- s_tkeep  input  8  byte enables; ignored (parsing depends only on beat index).
- in_key  output  96  key to db_top.
- in_flag  output  4  [0]=TCP, [1]=UDP, [2]=TCP SYN, [3]=TCP FIN.
- in_valid  output  1  single-cycle key strobe to db_top.
- pkt_cnt  output  32  frames seen (counts tlast beats).
- key_cnt  output  32  keys emitted.

Behaviour:
- Reset values:
  - in_key = 0, in_flag = 0, in_valid = 0, pkt_cnt = 0, key_cnt = 0.
  - Beat index = 0; state = S_HDR.
- Beat index:
  - Increments on each s_tvalid beat and saturates at 6.
  - Returns to 0 on the cycle after a tlast beat, so a new frame can start on the very next cycle.
- Captured fields (frame byte offsets, IHL=5 only):
  - ethertype: bytes 12-13 (beat1, bytes 4-5).
  - ver/IHL: byte 14.
  - flags/fragment offset: bytes 20-21 (beat2).
  - protocol: byte 23.
  - src_ip: bytes 26-29.
  - dst_ip: bytes 30-33 (spans beat3 and beat4).
  - src_port: bytes 34-35.
  - dst_port: bytes 36-37.
  - TCP flags: byte 47 (beat5, byte 7); FIN = bit 0, SYN = bit 1.
- States:
  - S_HDR: capturing beats 0-5.
  - S_SKIP: discarding payload until tlast.
  - Transitions:
    - S_HDR -> S_SKIP after beat5 when tlast is not set.
    - S_HDR -> S_HDR on tlast.
    - S_SKIP -> S_HDR on tlast.
- Qualification. A frame qualifies only if all of the following hold:
  - ethertype = 0x0800.
  - byte14 = 0x45.
  - MF = 0 and fragment offset = 0 (bytes 20-21 & 0x3FFF == 0).
  - protocol is 6 or 17.
  - The frame reaches the required beat: beat4 for UDP, beat5 for TCP.
  - A frame whose tlast arrives before that beat is dropped silently.
- Emission:
  - Evaluation happens on the tlast beat.
  - If the frame qualifies, in_key and in_flag are registered and in_valid is high on the next cycle, for exactly one cycle.
  - Latency is 1 cycle from the tlast beat.
  - in_key and in_flag hold their values until the next emission.
  - UDP frames force in_flag[3:2] to 0.
- Counters:
  - pkt_cnt increments on every tlast beat, qualifying or not.
  - key_cnt increments with every in_valid.
  - Both wrap modulo 2^32.
- Stream gaps: s_tvalid low mid-frame stalls parsing; state and beat index hold.
- Back-to-back frames:
  - A tlast beat followed immediately by beat0 of the next frame is parsed correctly.
  - Two 1-beat-apart emissions are impossible, because frames are at least 5 beats.
- Reset mid-frame:
  - Capture registers are discarded and a pending emission is cancelled; in_valid is 0 on the cycle after rst.
  - The next valid beat is treated as beat0.
  - A truncated frame's remainder fails qualification, with no special recovery.
- rst dominates s_tvalid in the same cycle.

Decomposition:
- Shared package kvs_pkg holds:
  - KEY_SIZE and the flag bit indices (FLAG_TCP=0, FLAG_UDP=1, FLAG_SYN=2, FLAG_FIN=3); db_top uses the same values.
  - ETH_TYPE_IPV4 = 16'h0800, IP_PROTO_TCP = 8'd6, IP_PROTO_UDP = 8'd17.
  - The parse-state enum.
- Single module; no sub-module. Header capture is a flat register bank indexed by beat number.

Test Plan:
- UDP 10.0.0.1:1234 -> 10.0.0.2:5678, 64-byte frame (8 beats):
  - in_valid for one cycle, 1 cycle after tlast.
  - in_key = 96'h0A000001_0A000002_04D2_162E; in_flag = 4'b0010.
  - key_cnt = 1, pkt_cnt = 1.
- TCP SYN (byte 47 = 0x02) and then TCP FIN|ACK (0x11), same tuple:
  - in_flag = 4'b0101, then 4'b1001.
  - Two in_valid pulses.
- Non-qualifying frames:
  - ARP (0x0806) -> no in_valid, pkt_cnt += 1.
  - IPv4 with IHL = 6 -> no in_valid, pkt_cnt += 1.
  - Fragment (bytes 20-21 = 0x2000) -> no in_valid, pkt_cnt += 1.
  - ICMP (protocol 1) -> no in_valid, pkt_cnt += 1.
- Truncated TCP frame with tlast on beat4 -> no in_valid, pkt_cnt += 1.
- Framing robustness:
  - Two UDP frames back-to-back with no idle -> two correct keys.
  - A UDP frame with s_tvalid deasserted for 3 cycles mid-header -> identical key to the unstalled case.
- Reset handling:
  - rst asserted on the tlast beat of a qualifying frame -> no in_valid, counters 0.
  - Next clean frame after reset -> key emitted normally.

Source files
------------

// File: rtl/kvs_pkg.sv
// kvs_pkg: key/flag layout, protocol constants and parse states shared by key_extractor and db_top
package kvs_pkg;
  localparam int KEY_SIZE = 96;
  localparam int FLAG_TCP = 0;
  localparam int FLAG_UDP = 1;
  localparam int FLAG_SYN = 2;
  localparam int FLAG_FIN = 3;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_TCP = 8'd6;
  localparam logic [7:0] IP_PROTO_UDP = 8'd17;
  typedef enum logic {S_HDR, S_SKIP} parse_state_e;
endpackage

// File: rtl/key_extractor_if.sv
// key_extractor_if: 64-bit receive stream (s_tdata/s_tvalid/s_tlast/s_tkeep); master drives, slave receives
interface key_extractor_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   s_tdata;
  logic                    s_tvalid;
  logic                    s_tlast;
  logic [DATA_WIDTH/8-1:0] s_tkeep;
  modport master (output s_tdata, s_tvalid, s_tlast, s_tkeep);
  modport slave (input s_tdata, s_tvalid, s_tlast, s_tkeep);
endinterface

// File: rtl/key_extractor.sv
// key_extractor: parses IPv4 TCP/UDP headers from the rx stream and emits one flow key + flags per qualifying frame
// Ports: clk, rst (sync, active-high); rx (slave receive stream); in_key/in_flag/in_valid toward db_top;
//        pkt_cnt counts tlast beats, key_cnt counts emitted keys.
module key_extractor
  import kvs_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  key_extractor_if.slave       rx,
  output logic [KEY_SIZE-1:0]  in_key,
  output logic [3:0]           in_flag,
  output logic                 in_valid,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] key_cnt
);
  parse_state_e state, state_n;
  logic [2:0] beat;
  logic [DATA_WIDTH-1:0] d;
  logic v, last, cap, is_tcp, is_udp, qual, emit, tkeep_unused;
  logic [15:0] eth_type, eth_type_n, src_port, src_port_n, dst_port, dst_port_n;
  logic [13:0] frag, frag_n;
  logic [7:0] ver_ihl, ver_ihl_n, proto, proto_n;
  logic [1:0] tcp_fl, tcp_fl_n;
  logic [31:0] src_ip, src_ip_n, dst_ip, dst_ip_n;
  logic [3:0] flag_n;
  assign d = rx.s_tdata;
  assign v = rx.s_tvalid;
  assign last = rx.s_tvalid && rx.s_tlast;
  assign tkeep_unused = ^rx.s_tkeep;
  assign cap = v && state == S_HDR;
  // Next-value view of the header fields: the tlast beat's own bytes must be visible to qualification
  always_comb begin
    eth_type_n = (cap && beat == 3'd1) ? {d[39:32], d[47:40]} : eth_type;
    ver_ihl_n  = (cap && beat == 3'd1) ? d[55:48] : ver_ihl;
    frag_n     = (cap && beat == 3'd2) ? {d[37:32], d[47:40]} : frag;
    proto_n    = (cap && beat == 3'd2) ? d[63:56] : proto;
    src_ip_n   = (cap && beat == 3'd3) ? {d[23:16], d[31:24], d[39:32], d[47:40]} : src_ip;
    dst_ip_n   = (cap && beat == 3'd3) ? {d[55:48], d[63:56], dst_ip[15:0]} :
                 (cap && beat == 3'd4) ? {dst_ip[31:16], d[7:0], d[15:8]} : dst_ip;
    src_port_n = (cap && beat == 3'd4) ? {d[23:16], d[31:24]} : src_port;
    dst_port_n = (cap && beat == 3'd4) ? {d[39:32], d[47:40]} : dst_port;
    tcp_fl_n   = (cap && beat == 3'd5) ? d[57:56] : tcp_fl;
  end
  assign is_tcp = proto_n == IP_PROTO_TCP;
  assign is_udp = proto_n == IP_PROTO_UDP;
  assign qual = eth_type_n == ETH_TYPE_IPV4 && ver_ihl_n == 8'h45 && frag_n == '0 &&
                ((is_tcp && beat >= 3'd5) || (is_udp && beat >= 3'd4));
  assign emit = last && qual;
  always_comb begin
    flag_n = '0;
    flag_n[FLAG_TCP] = is_tcp;
    flag_n[FLAG_UDP] = is_udp;
    flag_n[FLAG_SYN] = is_tcp && tcp_fl_n[1];
    flag_n[FLAG_FIN] = is_tcp && tcp_fl_n[0];
  end
  always_comb begin
    state_n = last ? S_HDR : (cap && beat == 3'd5) ? S_SKIP : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR;
      beat     <= '0;
      eth_type <= '0;
      ver_ihl  <= '0;
      frag     <= '0;
      proto    <= '0;
      src_ip   <= '0;
      dst_ip   <= '0;
      src_port <= '0;
      dst_port <= '0;
      tcp_fl   <= '0;
      in_key   <= '0;
      in_flag  <= '0;
      in_valid <= 1'b0;
      pkt_cnt  <= '0;
      key_cnt  <= '0;
    end else begin
      state    <= state_n;
      beat     <= !v ? beat : last ? 3'd0 : (beat == 3'd6) ? beat : beat + 3'd1;
      eth_type <= eth_type_n;
      ver_ihl  <= ver_ihl_n;
      frag     <= frag_n;
      proto    <= proto_n;
      src_ip   <= src_ip_n;
      dst_ip   <= dst_ip_n;
      src_port <= src_port_n;
      dst_port <= dst_port_n;
      tcp_fl   <= tcp_fl_n;
      in_valid <= emit;
      if (emit) begin
        in_key  <= {src_ip_n, dst_ip_n, src_port_n, dst_port_n};
        in_flag <= flag_n;
      end
      pkt_cnt  <= pkt_cnt + CNT_WIDTH'(last);
      key_cnt  <= key_cnt + CNT_WIDTH'(emit);
    end
  end
endmodule

// File: tb/tb_key_extractor.sv
// tb_key_extractor: directed frames with a scoreboard queue checked by an independent output monitor
module tb_key_extractor;
  typedef struct packed {
    logic [95:0] key;
    logic [3:0]  flag;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [95:0] in_key;
  logic [3:0] in_flag;
  logic in_valid;
  logic [31:0] pkt_cnt, key_cnt;
  logic [7:0] fr [0:63];
  exp_t exp_q [$];
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int exp_pkt = 0;
  int exp_key = 0;
  localparam logic [95:0] K_A = 96'h0A000001_0A000002_04D2_162E;
  localparam logic [95:0] K_B = 96'hC0A8010A_C0A80114_0050_0035;
  key_extractor_if #(.DATA_WIDTH(64)) rx ();
  key_extractor dut (
    .clk(clk), .rst(rst), .rx(rx.slave), .in_key(in_key), .in_flag(in_flag),
    .in_valid(in_valid), .pkt_cnt(pkt_cnt), .key_cnt(key_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (in_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_in_valid: got key %h flag %b expected none", in_key, in_flag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", 96'(cyc), 96'(e.cyc));
        chk("in_key", in_key, e.key);
        chk("in_flag", 96'(in_flag), 96'(e.flag));
      end
    end
  end
  task automatic build(input logic [15:0] et, input logic [7:0] vi, input logic [15:0] frag,
                       input logic [7:0] proto, input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] tfl);
    for (int i = 0; i < 64; i++) fr[i] = 8'(i * 7 + 3);
    {fr[12], fr[13]} = et;
    fr[14] = vi;
    {fr[20], fr[21]} = frag;
    fr[23] = proto;
    {fr[26], fr[27], fr[28], fr[29]} = sip;
    {fr[30], fr[31], fr[32], fr[33]} = dip;
    {fr[34], fr[35]} = sp;
    {fr[36], fr[37]} = dp;
    fr[47] = tfl;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx.s_tvalid = 1'b0;
      rx.s_tlast = 1'b0;
      rst = 1'b0;
    end
  endtask
  task automatic send(input int nb, input int stall_at, input int stall_len, input bit rst_last,
                      input bit ok, input logic [95:0] key, input logic [3:0] flag);
    for (int b = 0; b < nb; b++) begin
      if (b == stall_at) repeat (stall_len) begin
        @(negedge clk);
        rx.s_tvalid = 1'b0;
        rx.s_tlast = 1'b0;
        rx.s_tdata = '1;
      end
      @(negedge clk);
      for (int n = 0; n < 8; n++) rx.s_tdata[8*n +: 8] = fr[8*b + n];
      rx.s_tvalid = 1'b1;
      rx.s_tlast = (b == nb - 1);
      rx.s_tkeep = 8'hFF;
      if (b == nb - 1) begin
        rst = rst_last;
        if (rst_last) begin
          exp_pkt = 0;
          exp_key = 0;
        end else begin
          exp_pkt++;
          if (ok) begin
            exp_q.push_back('{key: key, flag: flag, cyc: cyc + 1});
            exp_key++;
          end
        end
      end
    end
  endtask
  task automatic chk_cnt(input string nm);
    chk({nm, "_pkt_cnt"}, 96'(pkt_cnt), 96'(exp_pkt));
    chk({nm, "_key_cnt"}, 96'(key_cnt), 96'(exp_key));
  endtask
  initial begin
    rst = 1'b1;
    rx.s_tdata = '0;
    rx.s_tvalid = 1'b0;
    rx.s_tlast = 1'b0;
    rx.s_tkeep = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_key", in_key, 96'd0);
    chk("reset_in_flag", 96'(in_flag), 96'd0);
    chk("reset_in_valid", 96'(in_valid), 96'd0);
    chk_cnt("reset");
    idle(2);
    build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h03);
    send(8, -1, 0, 0, 1, K_A, 4'b0010);
    idle(3);
    chk_cnt("udp");
    build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h02);
    send(8, -1, 0, 0, 1, K_A, 4'b0101);
    idle(2);
    build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h11);
    send(8, -1, 0, 0, 1, K_A, 4'b1001);
    idle(3);
    chk_cnt("tcp");
    build(16'h0806, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h00);
    send(8, -1, 0, 0, 0, '0, '0);
    idle(2);
    build(16'h0800, 8'h46, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h00);
    send(8, -1, 0, 0, 0, '0, '0);
    idle(2);
    build(16'h0800, 8'h45, 16'h2000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h00);
    send(8, -1, 0, 0, 0, '0, '0);
    idle(2);
    build(16'h0800, 8'h45, 16'h0000, 8'd1, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h00);
    send(8, -1, 0, 0, 0, '0, '0);
    idle(3);
    chk_cnt("nonqual");
    build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h02);
    send(5, -1, 0, 0, 0, '0, '0);
    idle(2);
    send(6, -1, 0, 0, 1, K_A, 4'b0101);
    idle(2);
    build(16'h0800, 8'h45, 16'h4000, 8'd17, 32'hC0A8010A, 32'hC0A80114, 16'd80, 16'd53, 8'h00);
    send(5, -1, 0, 0, 1, K_B, 4'b0010);
    idle(3);
    chk_cnt("boundary");
    build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'hC0A8010A, 32'hC0A80114, 16'd80, 16'd53, 8'h00);
    send(8, -1, 0, 0, 1, K_B, 4'b0010);
    build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd5678, 8'h00);
    send(8, -1, 0, 0, 1, K_A, 4'b0010);
    idle(3);
    chk_cnt("b2b");
    send(8, 2, 3, 0, 1, K_A, 4'b0010);
    idle(3);
    chk_cnt("stall");
    send(8, -1, 0, 1, 0, '0, '0);
    idle(1);
    chk("rst_in_valid", 96'(in_valid), 96'd0);
    idle(2);
    chk_cnt("rst");
    build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'hC0A8010A, 32'hC0A80114, 16'd80, 16'd53, 8'h11);
    send(8, -1, 0, 0, 1, K_B, 4'b1001);
    idle(4);
    chk_cnt("after_rst");
    chk("pending_keys", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
